// File: rtl/btn_debounce_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_debounce_if : slow-clock input, raw buttons and debounced event outputs
// Rev 1.0
// ---------------------------------------------------------------------------
interface btn_debounce_if #(
   parameter int N_BTN = 5
);
   logic             clk_debounce;
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic [N_BTN-1:0] btn_repeat;
   logic             sample_tick;

   modport master (
      output clk_debounce, btn_raw,
      input  btn_level, btn_press, btn_release, btn_repeat, sample_tick
   );

   modport slave (
      input  clk_debounce, btn_raw,
      output btn_level, btn_press, btn_release, btn_repeat, sample_tick
   );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_debounce : tick-sampled debouncer with press/release/auto-repeat pulses
// Rev 1.0
// ---------------------------------------------------------------------------
module btn_debounce #(
   parameter int N_BTN        = 5,
   parameter int STABLE_TICKS = 4,
   parameter int REPEAT_START = 250,
   parameter int REPEAT_RATE  = 50
) (
   input  wire logic     clk,
   input  wire logic     rst,
   btn_debounce_if.slave bus
);

   localparam logic [3:0] STABLE_CNT    = 4'(STABLE_TICKS);
   localparam logic [9:0] RPT_START_CNT = 10'(REPEAT_START);
   localparam logic [9:0] RPT_RATE_CNT  = 10'(REPEAT_RATE);

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

   logic             dbc_s1_q, dbc_s1_d;
   logic             dbc_s2_q, dbc_s2_d;
   logic             dbc_s3_q, dbc_s3_d;
   logic             tick_q, tick_d;
   logic [N_BTN-1:0] btn_s1_q, btn_s1_d;
   logic [N_BTN-1:0] sync_btn_q, sync_btn_d;

   always_comb begin
      dbc_s1_d   = bus.clk_debounce;
      dbc_s2_d   = dbc_s1_q;
      dbc_s3_d   = dbc_s2_q;
      tick_d     = dbc_s2_q & ~dbc_s3_q;
      btn_s1_d   = bus.btn_raw;
      sync_btn_d = btn_s1_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbc_s1_q   <= 1'b0;
         dbc_s2_q   <= 1'b0;
         dbc_s3_q   <= 1'b0;
         tick_q     <= 1'b0;
         btn_s1_q   <= '0;
         sync_btn_q <= '0;
      end else begin
         dbc_s1_q   <= dbc_s1_d;
         dbc_s2_q   <= dbc_s2_d;
         dbc_s3_q   <= dbc_s3_d;
         tick_q     <= tick_d;
         btn_s1_q   <= btn_s1_d;
         sync_btn_q <= sync_btn_d;
      end
   end

   assign bus.sample_tick = tick_q;

   generate
      for (genvar i = 0; i < N_BTN; i++) begin : g_btn
         logic [3:0] cnt_q, cnt_d;
         logic       level_q, level_d;
         logic       press_q, press_d;
         logic       release_q, release_d;
         rpt_state_e state_q, state_d;
         logic [9:0] rcnt_q, rcnt_d;
         logic       repeat_q, repeat_d;

         // Level flips in the same cycle the agree counter would reach STABLE_CNT.
         always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            if (tick_q) begin
               if (sync_btn_q[i] == level_q) begin
                  cnt_d = '0;
               end else if (cnt_q + 4'd1 == STABLE_CNT) begin
                  cnt_d   = '0;
                  level_d = ~level_q;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            press_d   = level_d & ~level_q;
            release_d = ~level_d & level_q;
         end

         // Release wins over a repeat hit landing on the same tick.
         always_comb begin
            state_d  = state_q;
            rcnt_d   = rcnt_q;
            repeat_d = 1'b0;
            if (release_d) begin
               state_d = RPT_IDLE;
               rcnt_d  = '0;
            end else begin
               case (state_q)
                  RPT_IDLE: begin
                     if (press_d) begin
                        state_d = RPT_DELAY;
                        rcnt_d  = '0;
                     end
                  end
                  RPT_DELAY: begin
                     if (tick_q) begin
                        if (rcnt_q + 10'd1 == RPT_START_CNT) begin
                           repeat_d = 1'b1;
                           rcnt_d   = '0;
                           state_d  = RPT_REPEAT;
                        end else begin
                           rcnt_d = rcnt_q + 10'd1;
                        end
                     end
                  end
                  RPT_REPEAT: begin
                     if (tick_q) begin
                        if (rcnt_q + 10'd1 == RPT_RATE_CNT) begin
                           repeat_d = 1'b1;
                           rcnt_d   = '0;
                        end else begin
                           rcnt_d = rcnt_q + 10'd1;
                        end
                     end
                  end
                  default: begin
                     state_d = RPT_IDLE;
                     rcnt_d  = '0;
                  end
               endcase
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_q     <= '0;
               level_q   <= 1'b0;
               press_q   <= 1'b0;
               release_q <= 1'b0;
               state_q   <= RPT_IDLE;
               rcnt_q    <= '0;
               repeat_q  <= 1'b0;
            end else begin
               cnt_q     <= cnt_d;
               level_q   <= level_d;
               press_q   <= press_d;
               release_q <= release_d;
               state_q   <= state_d;
               rcnt_q    <= rcnt_d;
               repeat_q  <= repeat_d;
            end
         end

         assign bus.btn_level[i]   = level_q;
         assign bus.btn_press[i]   = press_q;
         assign bus.btn_release[i] = release_q;
         assign bus.btn_repeat[i]  = repeat_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_btn_debounce : randomized bench for btn_debounce against a window model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_btn_debounce;
   localparam int N_BTN        = 5;
   localparam int STABLE_TICKS = 4;
   localparam int REPEAT_START = 5;
   localparam int REPEAT_RATE  = 2;
   localparam int VW           = 4 * N_BTN + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   btn_debounce_if #(.N_BTN(N_BTN)) bus ();

   btn_debounce #(
      .N_BTN        (N_BTN),
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_START (REPEAT_START),
      .REPEAT_RATE  (REPEAT_RATE)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: full per-tick sample history plus the tick of each change.
   int               t_idx = 0;
   logic [N_BTN-1:0] samp[$];
   int               last_chg[N_BTN];
   int               press_t[N_BTN];
   logic [N_BTN-1:0] m_level   = '0;
   logic [N_BTN-1:0] m_press   = '0;
   logic [N_BTN-1:0] m_release = '0;
   logic [N_BTN-1:0] m_repeat  = '0;

   int tick_cnt = 0;
   int press_cnt[N_BTN];
   int rel_cnt[N_BTN];
   int rep_cnt[N_BTN];

   function automatic logic [VW-1:0] outs();
      return {bus.sample_tick, bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat};
   endfunction

   task automatic clr_cnt();
      tick_cnt = 0;
      for (int b = 0; b < N_BTN; b++) begin
         press_cnt[b] = 0;
         rel_cnt[b]   = 0;
         rep_cnt[b]   = 0;
      end
   endtask

   task automatic model_reset();
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      m_repeat  = '0;
      for (int b = 0; b < N_BTN; b++) last_chg[b] = t_idx - 1;
   endtask

   // Level flips once the last STABLE_TICKS samples since the previous flip all disagree.
   task automatic model_step(input logic [N_BTN-1:0] raw);
      int t;
      t = t_idx;
      samp.push_back(raw);
      m_press   = '0;
      m_release = '0;
      m_repeat  = '0;
      for (int b = 0; b < N_BTN; b++) begin
         logic flip;
         int   d;
         flip = (t - last_chg[b] >= STABLE_TICKS);
         for (int j = 0; j < STABLE_TICKS; j++)
            if (flip && samp[t-j][b] == m_level[b]) flip = 1'b0;
         if (flip) begin
            m_level[b]  = ~m_level[b];
            last_chg[b] = t;
            if (m_level[b]) begin
               m_press[b] = 1'b1;
               press_t[b] = t;
            end else begin
               m_release[b] = 1'b1;
            end
         end else if (m_level[b]) begin
            d = t - press_t[b];
            if (d == REPEAT_START || (d > REPEAT_START && (d - REPEAT_START) % REPEAT_RATE == 0))
               m_repeat[b] = 1'b1;
         end
      end
      t_idx++;
   endtask

   // One clk_debounce period: raw held stable, every output compared on every negedge.
   task automatic run_tick(input logic [N_BTN-1:0] raw, input int hi, input int lo);
      logic [VW-1:0]    got, want, mask;
      logic [N_BTN-1:0] pp, pr, prp;
      int               tk;
      tk = 0;
      bus.btn_raw = raw;
      for (int k = -3; k <= hi + lo; k++) begin
         @(negedge clk);
         got  = outs();
         mask = '1;
         pp   = '0;
         pr   = '0;
         prp  = '0;
         if (tk != 0 && k == tk + 1) begin
            pp  = m_press;
            pr  = m_release;
            prp = m_repeat;
         end
         want = {1'b0, m_level, pp, pr, prp};
         if (k == 3) begin
            mask[VW-1] = 1'b0;
            if (got[VW-1] === 1'b1) tk = 3;
         end else if (k == 4 && tk == 0) begin
            want[VW-1] = 1'b1;
            tk = 4;
         end
         n_checks++;
         if ((got & mask) !== (want & mask)) begin
            n_fail++;
            $display("FAIL tick_window t=%0d k=%0d: got %b required %b", t_idx, k, got & mask, want & mask);
         end
         if (got[VW-1] === 1'b1) tick_cnt++;
         for (int b = 0; b < N_BTN; b++) begin
            if (got[2*N_BTN + b] === 1'b1) press_cnt[b]++;
            if (got[N_BTN + b]   === 1'b1) rel_cnt[b]++;
            if (got[b]           === 1'b1) rep_cnt[b]++;
         end
         if (tk != 0 && k == tk) model_step(raw);
         if (k == 0)  bus.clk_debounce = 1'b1;
         if (k == hi) bus.clk_debounce = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [VW-1:0] got;
      rst = 1'b1;
      bus.btn_raw = '1;
      bus.clk_debounce = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         got = outs();
         n_checks++;
         if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b required %b", got, {VW{1'b0}});
         end
         if (k % 2 == 1) bus.clk_debounce = ~bus.clk_debounce;
      end
      bus.clk_debounce = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      clr_cnt();
      repeat (5) run_tick('1, 2, 5);
      n_checks++;
      if (bus.btn_level !== 5'b11111) begin
         n_fail++;
         $display("FAIL reset_release_level: got %b required %b", bus.btn_level, 5'b11111);
      end
      for (int b = 0; b < N_BTN; b++) begin
         n_checks++;
         if (press_cnt[b] != 1) begin
            n_fail++;
            $display("FAIL reset_release_press[%0d]: got %0d required 1", b, press_cnt[b]);
         end
      end
      repeat (5) run_tick('0, 3, 5);
   endtask

   task automatic test_clean_press();
      clr_cnt();
      repeat (6) run_tick(5'b00001, $urandom_range(2, 5), $urandom_range(4, 8));
      n_checks++;
      if (press_cnt[0] != 1 || rel_cnt[0] != 0 || bus.btn_level[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL clean_press: got press=%0d release=%0d level=%b required 1 0 1",
                  press_cnt[0], rel_cnt[0], bus.btn_level[0]);
      end
      repeat (5) run_tick(5'b00000, 2, 6);
      n_checks++;
      if (rel_cnt[0] != 1) begin
         n_fail++;
         $display("FAIL clean_release: got %0d required 1", rel_cnt[0]);
      end
   endtask

   task automatic test_bounce();
      logic [N_BTN-1:0] r;
      clr_cnt();
      r = 5'b00010;
      for (int i = 0; i < 7; i++) begin
         run_tick(r, 2, 5);
         r = r ^ 5'b00010;
      end
      n_checks++;
      if (press_cnt[1] != 0) begin
         n_fail++;
         $display("FAIL bounce_no_press: got %0d required 0", press_cnt[1]);
      end
      repeat (5) run_tick(5'b00010, 2, 5);
      repeat (3) run_tick(5'b00000, 2, 5);
      repeat (3) run_tick(5'b00010, 2, 5);
      n_checks++;
      if (press_cnt[1] != 1 || rel_cnt[1] != 0 || bus.btn_level[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL bounce_glitch: got press=%0d release=%0d level=%b required 1 0 1",
                  press_cnt[1], rel_cnt[1], bus.btn_level[1]);
      end
      repeat (5) run_tick(5'b00000, 2, 5);
   endtask

   task automatic test_repeat();
      clr_cnt();
      repeat (13) run_tick(5'b00100, $urandom_range(2, 4), $urandom_range(4, 6));
      n_checks++;
      if (rep_cnt[2] != 3) begin
         n_fail++;
         $display("FAIL repeat_count: got %0d required 3", rep_cnt[2]);
      end
      // Release lands on the tick where the fifth repeat would fire.
      repeat (4) run_tick(5'b00000, 2, 5);
      n_checks++;
      if (rep_cnt[2] != 4 || rel_cnt[2] != 1 || bus.btn_level[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL repeat_release: got repeat=%0d release=%0d level=%b required 4 1 0",
                  rep_cnt[2], rel_cnt[2], bus.btn_level[2]);
      end
   endtask

   task automatic test_back_to_back();
      clr_cnt();
      repeat (6) run_tick('1, 2, 4);
      repeat (6) run_tick('0, 2, 4);
      for (int b = 0; b < N_BTN; b++) begin
         n_checks++;
         if (press_cnt[b] != 1 || rel_cnt[b] != 1) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: got press=%0d release=%0d required 1 1",
                     b, press_cnt[b], rel_cnt[b]);
         end
      end
   endtask

   task automatic test_tick_count();
      clr_cnt();
      for (int i = 0; i < 100; i++) run_tick(bus.btn_raw, 2, $urandom_range(4, 6));
      n_checks++;
      if (tick_cnt != 100) begin
         n_fail++;
         $display("FAIL tick_count: got %0d required 100", tick_cnt);
      end
   endtask

   task automatic test_random();
      logic [N_BTN-1:0] r;
      r = bus.btn_raw;
      for (int i = 0; i < 150; i++) begin
         for (int b = 0; b < N_BTN; b++)
            if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
         run_tick(r, $urandom_range(2, 5), $urandom_range(4, 8));
      end
      repeat (5) run_tick('0, 2, 5);
   endtask

   task automatic test_midreset();
      logic [VW-1:0] got;
      repeat (5) run_tick(5'b10000, 2, 5);
      repeat (2) run_tick(5'b11000, 2, 5);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 got = outs();
      n_checks++;
      if (got !== '0) begin
         n_fail++;
         $display("FAIL midreset_async: got %b required %b", got, {VW{1'b0}});
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         got = outs();
         n_checks++;
         if (got !== '0) begin
            n_fail++;
            $display("FAIL midreset_hold: got %b required %b", got, {VW{1'b0}});
         end
      end
      rst = 1'b0;
      model_reset();
      clr_cnt();
      repeat (4) run_tick(5'b11000, 2, 5);
      n_checks++;
      if (press_cnt[3] != 1 || press_cnt[4] != 1) begin
         n_fail++;
         $display("FAIL midreset_requalify: got press3=%0d press4=%0d required 1 1",
                  press_cnt[3], press_cnt[4]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_repeat();
      test_back_to_back();
      test_tick_count();
      test_random();
      test_midreset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Consumer of the slow debounce clock produced by the clock generator.
- Runs entirely on the 100 MHz board clock. It synchronizes clk_debounce and converts its rising edges into one-cycle sample ticks, then debounces N_BTN raw push-buttons.
- Emits per-button clean levels plus one-cycle press, release and auto-repeat pulses for the 24game input/control FSM.

Parameters:
- N_BTN, 5, number of buttons debounced in parallel.
- STABLE_TICKS, 4, consecutive agreeing samples required to change a clean level (range 1..15).
- REPEAT_START, 250, ticks a button must stay pressed before the first repeat pulse (range 1..1023).
- REPEAT_RATE, 50, ticks between subsequent repeat pulses (range 1..1023).

Ports:
- clk  input  1  100 MHz board clock.
- rst  input  1  asynchronous, active-high reset.
- clk_debounce  input  1  slow clock from the clock generator; asynchronous to this block's logic and treated as data.
- btn_raw  input  N_BTN  raw, bouncing, asynchronous button inputs; active-high = pressed.
- btn_level  output  N_BTN  debounced level.
- btn_press  output  N_BTN  one-clk pulse on each 0->1 of btn_level.
- btn_release  output  N_BTN  one-clk pulse on each 1->0 of btn_level.
- btn_repeat  output  N_BTN  one-clk auto-repeat pulse while held.
- sample_tick  output  1  one-clk pulse per detected clk_debounce rising edge; for observation.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0.
  - Synchronizer flops 0; per-button agree counters 0.
  - Repeat FSMs in IDLE; repeat counters 0.
- Tick generation:
  - clk_debounce passes through 2 sync flops (s1, s2), then an edge flop s3.
  - sample_tick = s2 & ~s3, registered, so it is high for exactly one clk.
  - Latency from a clk_debounce rise to sample_tick is 3-4 clk.
  - clk_debounce must be high ≥2 clk and low ≥2 clk. Narrower pulses may be missed; this is not an error.
- Input sync: each btn_raw bit passes through 2 flops to give sync_btn. No logic acts on the raw bits.
- Debounce, per button, evaluated only in cycles with sample_tick=1:
  - If sync_btn == btn_level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the incremented value equals STABLE_TICKS, the counter clears and btn_level toggles at that same clk edge.
  - Between ticks the counter holds.
  - The counter is 4 bits and never exceeds STABLE_TICKS.
- Edge pulses:
  - btn_press and btn_release are registered. They are high for the single clk immediately after the edge at which btn_level changed.
  - Press and release for one button are never high together.
- Repeat FSM, per button. States are IDLE, DELAY and REPEAT.
  - IDLE -> DELAY on btn_level 0->1; the repeat counter loads 0.
  - DELAY: the counter increments on each tick. When it reaches REPEAT_START: emit btn_repeat for 1 clk, counter loads 0, go to REPEAT.
  - REPEAT: the counter increments on each tick. When it reaches REPEAT_RATE: emit btn_repeat, counter loads 0.
  - Any state -> IDLE on btn_level 1->0. This takes priority over a same-cycle repeat hit: no btn_repeat is emitted in that cycle.
  - btn_repeat never coincides with btn_press.
  - Counter width is 10 bits.
- Buttons are fully independent. Simultaneous changes on all N_BTN bits produce simultaneous pulses.
- Mid-operation reset: asserting rst at any time clears everything immediately with no pulse. After rst is deasserted, a button still held re-qualifies from 0 and produces a fresh btn_press.
- sample_tick and btn_* bits change only on posedge clk or on rst.

Test Plan:
- Reset: rst=1 with btn_raw=5'b11111 and clk_debounce toggling -> every output stays 0. Release rst -> btn_level=5'b11111 after 4 ticks, with one btn_press pulse per bit.
- Clean press: btn_raw[0] 0->1 held, ticks every 200 clk -> btn_level[0] rises on the 4th tick plus 1 clk. Exactly one btn_press[0] pulse; btn_release stays 0.
- Bounce rejection:
  - btn_raw[1] toggles every 150 clk for 1000 clk, then settles at 1 -> no level change during bouncing.
  - btn_level[1] rises exactly 4 ticks after the last agreeing sample.
  - A 3-tick glitch with STABLE_TICKS=4 -> no pulse.
- Auto-repeat (REPEAT_START=5, REPEAT_RATE=2 in the bench) -> btn_repeat[2] at ticks 5, 7 and 9 after the press.
  - Release on the tick where a repeat would fire -> btn_release only, no btn_repeat.
- Tick detection: clk_debounce high for 2 clk -> sample_tick fires once. High for 1 clk -> no requirement. 100 rising edges -> exactly 100 sample_tick pulses.
- Mid-count reset: assert rst after tick 2 of 4 while btn_raw[3]=1 -> all outputs 0 at once. After release, btn_press[3] occurs after 4 new ticks.
